spi_frame_master: RTL and testbench
===================================

// Module: spi_frame_master
// PURPOSE
//  Parametrised SPI master for the ADS131A0x front end, clocked from the 4.167 MHz synthesized clock.
//  After reset it runs the ADC hardware-reset sequence, then performs full-duplex frames of
//  NUM_WORDS x WORD_BITS bits (status + channel words), triggered by a request or by DRDY.
//  Sits between the NIOS/host request logic and the ADC pins.
// PARAMETERS
//  WORD_BITS       24     bits per SPI word
//  NUM_WORDS       5      words per frame (ADS131A04: status + 4 channels)
//  CPOL            0      SCLK idle level
//  CPHA            1      0: sample on leading edge; 1: drive on leading, sample on trailing
//  CS_SETUP_CYC    2      clk cycles CS_N low before first SCLK edge (>=1)
//  CS_HOLD_CYC     2      clk cycles after last SCLK edge before CS_N rises (>=1)
//  CS_GAP_CYC      4      min clk cycles CS_N high between frames (>=1)
//  RESET_LOW_CYC   20835  ADC RESET low time (5 ms)
//  RESET_WAIT_CYC  83340  wait after RESET release before init_done (20 ms)
//  AUTO_DRDY       0      1: falling edge of drdy_n also requests a frame
// PORTS
//  synthesized_clock_4_167Mhz  in   1                     clock; all logic on rising edge
//  reset_n                     in   1                     asynchronous reset, active-low
//  adc_init                    in   1                     pulse: re-run ADC reset sequence
//  frame_req                   in   1                     request one frame
//  drdy_n                      in   1                     ADC DRDY, async, active-low
//  tx_data                     in   NUM_WORDS*WORD_BITS   frame to send, MSB sent first
//  rx_data                     out  NUM_WORDS*WORD_BITS   last received frame, MSB first
//  frame_done                  out  1                     1-cycle pulse: rx_data updated
//  busy                        out  1                     high outside IDLE
//  init_done                   out  1                     ADC reset sequence complete
//  overrun                     out  1                     1-cycle pulse: trigger lost while busy
//  state                       out  3                     current FSM state (debug)
//  SPI_SCLK / SPI_MOSI / SPI_CS / SPI_RESET  out 1 each    SPI_CS active-low; SPI_RESET active-low
//  SPI_MISO                    in   1                     serial data from ADC
// BEHAVIOUR
//  Reset (async): state=RST_LOW; SPI_RESET=0, SPI_CS=1, SPI_SCLK=CPOL, SPI_MOSI=0, rx_data=0,
//   frame_done=0, overrun=0, init_done=0, busy=1, all counters 0.
//  FSM (state encoding): RST_LOW=0, RST_WAIT=1, IDLE=2, SETUP=3, SHIFT=4, HOLD=5, GAP=6.
//  RST_LOW: SPI_RESET=0 for RESET_LOW_CYC cycles -> RST_WAIT (SPI_RESET=1).
//  RST_WAIT: RESET_WAIT_CYC cycles -> IDLE, init_done=1 on the same edge.
//  IDLE: adc_init=1 -> RST_LOW, init_done=0 (adc_init has priority over triggers).
//   trigger = frame_req | (AUTO_DRDY & synced drdy_n fall) -> capture tx_data into shift reg,
//   SPI_CS=0, -> SETUP. drdy_n goes through a 2-flop synchroniser; edge detected on synced value.
//  SETUP: CS_SETUP_CYC cycles, SCLK=CPOL; CPHA=0: MOSI=bit FRAME-1 on entry.
//  SHIFT: 2 clk per bit, half A (SCLK=CPOL) then half B (SCLK=~CPOL).
//   CPHA=0: MOSI updates at start of A; MISO sampled at end of A.
//   CPHA=1: MOSI updates at start of B; MISO sampled at end of B.
//   After FRAME_BITS=NUM_WORDS*WORD_BITS bits -> HOLD; SCLK returns to CPOL.
//  HOLD: CS_HOLD_CYC cycles, SPI_CS=0 -> GAP; on the edge entering GAP: SPI_CS=1,
//   rx_data<=shift-in reg, frame_done=1 for one cycle.
//  GAP: CS_GAP_CYC cycles, SPI_CS=1 -> IDLE.
//  Frame latency trigger->frame_done = 1+CS_SETUP_CYC+2*FRAME_BITS+CS_HOLD_CYC cycles.
//  Triggers outside IDLE are dropped; each dropped trigger pulses overrun (frame_req counts only if
//   high in a non-IDLE cycle following one where it was low, i.e. on its rising edge).
//  In RST_LOW/RST_WAIT, triggers are ignored without overrun; adc_init is ignored outside IDLE.
//  rx_data changes only on frame_done; tx_data changes after capture do not affect the frame.
//  Bit/word/cycle counters sized with $clog2; terminal count compares exact, no wrap past limit.
//  reset_n low mid-frame: immediate abort, SPI_CS=1, no frame_done, sequence restarts at RST_LOW.
// TESTING (bench params: WORD_BITS=8 NUM_WORDS=2 RESET_LOW_CYC=4 RESET_WAIT_CYC=6, others default)
//  1 Release reset -> SPI_RESET low 4 cycles, high, init_done rises 6 cycles later, state=2.
//  2 CPHA=1 CPOL=0, tx_data=16'hA55A, MISO model returns 16'h3CC3 -> MOSI shows A55A MSB first,
//    16 SCLK pulses, rx_data=16'h3CC3, frame_done 1+2+32+2=37 cycles after frame_req.
//  3 CPHA=0 CPOL=1, same data -> SCLK idles high, MISO sampled on leading (falling) edge, rx=16'h3CC3.
//  4 frame_req pulsed mid-SHIFT -> overrun pulse, exactly one frame, CS_N high >=4 cycles after.
//  5 AUTO_DRDY=1, drdy_n falls in IDLE -> frame starts 3 cycles later (sync+edge); adc_init in IDLE
//    -> init_done=0, full reset sequence repeats.
//  6 reset_n asserted at bit 5 of a frame -> SPI_CS=1 immediately, no frame_done, rx_data=0.

Source files
------------

// File: rtl/spi_frame_master.sv
// SPI frame master for the ADS131A0x front end.
// ADC reset sequencing plus full-duplex multi-word frames.
module spi_frame_master #(
  parameter int WORD_BITS      = 24,
  parameter int NUM_WORDS      = 5,
  parameter int CPOL           = 0,
  parameter int CPHA           = 1,
  parameter int CS_SETUP_CYC   = 2,
  parameter int CS_HOLD_CYC    = 2,
  parameter int CS_GAP_CYC     = 4,
  parameter int RESET_LOW_CYC  = 20835,
  parameter int RESET_WAIT_CYC = 83340,
  parameter int AUTO_DRDY      = 0
) (
  input  logic                           synthesized_clock_4_167Mhz,
  input  logic                           reset_n,
  input  logic                           adc_init,
  input  logic                           frame_req,
  input  logic                           drdy_n,
  input  logic [NUM_WORDS*WORD_BITS-1:0] tx_data,
  output logic [NUM_WORDS*WORD_BITS-1:0] rx_data,
  output logic                           frame_done,
  output logic                           busy,
  output logic                           init_done,
  output logic                           overrun,
  output logic [2:0]                     state,
  output logic                           SPI_SCLK,
  output logic                           SPI_MOSI,
  output logic                           SPI_CS,
  output logic                           SPI_RESET,
  input  logic                           SPI_MISO
);

  localparam int FB = NUM_WORDS * WORD_BITS;
  localparam int M1 = (RESET_LOW_CYC > RESET_WAIT_CYC)
                    ? RESET_LOW_CYC : RESET_WAIT_CYC;
  localparam int M2 = (CS_SETUP_CYC > CS_HOLD_CYC)
                    ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int M3 = (M2 > CS_GAP_CYC) ? M2 : CS_GAP_CYC;
  localparam int MAXC = (M1 > M3) ? M1 : M3;
  localparam int CW = $clog2(MAXC + 1);
  localparam int BW = $clog2(FB + 1);

  localparam logic [CW-1:0] LOW_LAST   = CW'(RESET_LOW_CYC - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(RESET_WAIT_CYC - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FB - 1);
  localparam logic          SCLK_IDLE  = (CPOL != 0);
  localparam logic          AUTO       = (AUTO_DRDY != 0);

  typedef enum logic [2:0] {
    RST_LOW  = 3'd0,
    RST_WAIT = 3'd1,
    IDLE     = 3'd2,
    SETUP    = 3'd3,
    SHIFT    = 3'd4,
    HOLD     = 3'd5,
    GAP      = 3'd6
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cyc_q;
  logic [BW-1:0] bit_q;
  logic          half_q;
  logic [FB-1:0] tx_sh_q;
  logic [FB-1:0] rx_sh_q;
  logic [FB-1:0] rx_q;
  logic          sclk_q;
  logic          mosi_q;
  logic          cs_q;
  logic          rst_q;
  logic          done_q;
  logic          busy_q;
  logic          init_q;
  logic          ovr_q;
  logic          drdy_s1_q;
  logic          drdy_s2_q;
  logic          drdy_s3_q;
  logic          req_prev_q;

  logic drdy_fall;
  logic trig;
  logic lost;
  logic active;

  assign drdy_fall = drdy_s3_q & ~drdy_s2_q;
  assign trig      = frame_req | (AUTO & drdy_fall);
  assign lost      = (frame_req & ~req_prev_q) | (AUTO & drdy_fall);
  assign active    = (state_q == SETUP) | (state_q == SHIFT)
                   | (state_q == HOLD)  | (state_q == GAP);

  // DRDY synchroniser with one extra stage for fall detection
  always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n) begin
    if (!reset_n) begin
      drdy_s1_q  <= 1'b1;
      drdy_s2_q  <= 1'b1;
      drdy_s3_q  <= 1'b1;
      req_prev_q <= 1'b0;
    end else begin
      drdy_s1_q  <= drdy_n;
      drdy_s2_q  <= drdy_s1_q;
      drdy_s3_q  <= drdy_s2_q;
      req_prev_q <= frame_req;
    end
  end

  // Sequencer: ADC reset, then CS setup / bit shifting / hold / gap
  always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_LOW;
      cyc_q   <= '0;
      bit_q   <= '0;
      half_q  <= 1'b0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      sclk_q  <= SCLK_IDLE;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      rst_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      init_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovr_q  <= lost & active;
      unique case (state_q)
        RST_LOW: begin
          if (cyc_q == LOW_LAST) begin
            state_q <= RST_WAIT;
            rst_q   <= 1'b1;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        RST_WAIT: begin
          if (cyc_q == WAIT_LAST) begin
            state_q <= IDLE;
            init_q  <= 1'b1;
            busy_q  <= 1'b0;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        IDLE: begin
          if (adc_init) begin
            state_q <= RST_LOW;
            init_q  <= 1'b0;
            rst_q   <= 1'b0;
            busy_q  <= 1'b1;
            cyc_q   <= '0;
          end else if (trig) begin
            state_q <= SETUP;
            busy_q  <= 1'b1;
            cs_q    <= 1'b0;
            cyc_q   <= '0;
            if (CPHA == 0) begin
              mosi_q  <= tx_data[FB-1];
              tx_sh_q <= {tx_data[FB-2:0], 1'b0};
            end else begin
              tx_sh_q <= tx_data;
            end
          end
        end
        SETUP: begin
          if (cyc_q == SETUP_LAST) begin
            state_q <= SHIFT;
            cyc_q   <= '0;
            bit_q   <= '0;
            half_q  <= 1'b0;
            sclk_q  <= SCLK_IDLE;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        SHIFT: begin
          if (!half_q) begin
            half_q <= 1'b1;
            sclk_q <= ~SCLK_IDLE;
            if (CPHA != 0) begin
              mosi_q  <= tx_sh_q[FB-1];
              tx_sh_q <= {tx_sh_q[FB-2:0], 1'b0};
            end else begin
              rx_sh_q <= {rx_sh_q[FB-2:0], SPI_MISO};
            end
          end else begin
            half_q <= 1'b0;
            sclk_q <= SCLK_IDLE;
            if (CPHA != 0) begin
              rx_sh_q <= {rx_sh_q[FB-2:0], SPI_MISO};
            end
            if (bit_q == BIT_LAST) begin
              state_q <= HOLD;
              cyc_q   <= '0;
            end else begin
              bit_q <= bit_q + BW'(1);
              if (CPHA == 0) begin
                mosi_q  <= tx_sh_q[FB-1];
                tx_sh_q <= {tx_sh_q[FB-2:0], 1'b0};
              end
            end
          end
        end
        HOLD: begin
          if (cyc_q == HOLD_LAST) begin
            state_q <= GAP;
            cs_q    <= 1'b1;
            rx_q    <= rx_sh_q;
            done_q  <= 1'b1;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        GAP: begin
          if (cyc_q == GAP_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        default: begin
          state_q <= RST_LOW;
          cyc_q   <= '0;
        end
      endcase
    end
  end

  assign rx_data    = rx_q;
  assign frame_done = done_q;
  assign busy       = busy_q;
  assign init_done  = init_q;
  assign overrun    = ovr_q;
  assign state      = state_q;
  assign SPI_SCLK   = sclk_q;
  assign SPI_MOSI   = mosi_q;
  assign SPI_CS     = cs_q;
  assign SPI_RESET  = rst_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: two instances (mode 1 / mode 2 + DRDY)
// driven against an ideal SPI slave that swaps whole frames.
module tb_spi_frame_master;

  localparam int F = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   rstn  = 2'b00;
  logic [1:0]   ainit = 2'b00;
  logic [1:0]   freq  = 2'b00;
  logic [1:0]   drdy  = 2'b11;
  logic [1:0]   miso  = 2'b00;
  logic [F-1:0] txd [2];
  logic [F-1:0] rxd [2];
  logic [2:0]   st  [2];
  wire  [1:0]   sclkv, csv, mosiv, fdone, busyv, initd, ovr, spirst;

  spi_frame_master #(
    .WORD_BITS(8), .NUM_WORDS(2), .CPOL(0), .CPHA(1),
    .RESET_LOW_CYC(4), .RESET_WAIT_CYC(6), .AUTO_DRDY(0)
  ) u_a (
    .synthesized_clock_4_167Mhz(clk), .reset_n(rstn[0]),
    .adc_init(ainit[0]), .frame_req(freq[0]), .drdy_n(drdy[0]),
    .tx_data(txd[0]), .rx_data(rxd[0]), .frame_done(fdone[0]),
    .busy(busyv[0]), .init_done(initd[0]), .overrun(ovr[0]),
    .state(st[0]), .SPI_SCLK(sclkv[0]), .SPI_MOSI(mosiv[0]),
    .SPI_CS(csv[0]), .SPI_RESET(spirst[0]), .SPI_MISO(miso[0])
  );

  spi_frame_master #(
    .WORD_BITS(8), .NUM_WORDS(2), .CPOL(1), .CPHA(0),
    .RESET_LOW_CYC(4), .RESET_WAIT_CYC(6), .AUTO_DRDY(1)
  ) u_b (
    .synthesized_clock_4_167Mhz(clk), .reset_n(rstn[1]),
    .adc_init(ainit[1]), .frame_req(freq[1]), .drdy_n(drdy[1]),
    .tx_data(txd[1]), .rx_data(rxd[1]), .frame_done(fdone[1]),
    .busy(busyv[1]), .init_done(initd[1]), .overrun(ovr[1]),
    .state(st[1]), .SPI_SCLK(sclkv[1]), .SPI_MOSI(mosiv[1]),
    .SPI_CS(csv[1]), .SPI_RESET(spirst[1]), .SPI_MISO(miso[1])
  );

  // Ideal slave: presents pat[g] MSB first, records MOSI
  logic [F-1:0] pat  [2];
  logic [F-1:0] mcap [2];
  int           lcnt [2];
  int           tcnt [2];
  logic [1:0]   pcpol = 2'b10;
  logic [1:0]   pcpha = 2'b01;
  logic [1:0]   psclk = 2'b10;
  logic [1:0]   pcs   = 2'b11;

  always @(sclkv or csv) begin
    for (int g = 0; g < 2; g++) begin
      if (pcs[g] && !csv[g]) begin
        lcnt[g] = 0;
        tcnt[g] = 0;
        mcap[g] = '0;
        if (!pcpha[g]) miso[g] = pat[g][F-1];
      end else if (!csv[g] && sclkv[g] != psclk[g]) begin
        if (sclkv[g] != pcpol[g]) begin
          if (pcpha[g]) begin
            if (lcnt[g] < F) miso[g] = pat[g][F-1-lcnt[g]];
          end else begin
            mcap[g] = {mcap[g][F-2:0], mosiv[g]};
          end
          lcnt[g]++;
        end else begin
          if (pcpha[g]) begin
            mcap[g] = {mcap[g][F-2:0], mosiv[g]};
          end else begin
            tcnt[g]++;
            if (tcnt[g] < F) miso[g] = pat[g][F-1-tcnt[g]];
          end
        end
      end
    end
    psclk = sclkv;
    pcs   = csv;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (busyv[i] && n < 200) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(n < 200), 1);
  endtask

  // Caller is at #1 after the edge that entered RST_LOW
  task automatic measure_reset(input int i);
    int n = 0;
    int ov = 0;
    while (!spirst[i] && n < 100) begin
      freq[i] = (n == 1);
      tick();
      n++;
      ov += int'(ovr[i]);
    end
    chk("rst_low_cycles", n, 4);
    n = 0;
    while (!initd[i] && n < 100) begin
      freq[i] = (n == 2);
      tick();
      n++;
      ov += int'(ovr[i]);
    end
    freq[i] = 1'b0;
    chk("rst_wait_cycles", n, 6);
    chk("idle_state", st[i], 2);
    chk("idle_busy", busyv[i], 0);
    chk("no_ovr_in_reset", ov, 0);
  endtask

  task automatic run_frame(input int i, input logic [F-1:0] tx,
                           input logic [F-1:0] p,
                           input logic [F-1:0] exp_rx,
                           input logic [F-1:0] exp_mosi);
    int n;
    pat[i]  = p;
    txd[i]  = tx;
    freq[i] = 1'b1;
    tick();
    freq[i] = 1'b0;
    txd[i]  = ~tx;
    n = 1;
    while (!fdone[i] && n < 200) begin
      tick();
      n++;
    end
    chk("latency", n, 37);
    chk("rx_data", rxd[i], exp_rx);
    chk("mosi_stream", mcap[i], exp_mosi);
    chk("sclk_pulses", lcnt[i], 16);
    chk("cs_high_at_done", csv[i], 1);
    tick();
    chk("done_one_cycle", fdone[i], 0);
    chk("sclk_idle", sclkv[i], 32'(i == 1));
    wait_idle(i);
  endtask

  typedef struct {
    logic [F-1:0] tx;
    logic [F-1:0] miso;
    logic [F-1:0] exp_rx;
    logic [F-1:0] exp_mosi;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int n;
    int nd;
    int novr;
    int nlow;
    int ri;
    logic seen;
    logic [F-1:0] rt;
    logic [F-1:0] rp;

    tbl[0] = '{16'hA55A, 16'h3CC3, 16'h3CC3, 16'hA55A};
    tbl[1] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
    tbl[2] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
    tbl[3] = '{16'h8001, 16'h7FFE, 16'h7FFE, 16'h8001};
    txd[0] = '0;
    txd[1] = '0;
    pat[0] = '0;
    pat[1] = '0;

    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_spi_reset", spirst[i], 0);
      chk("rst_cs", csv[i], 1);
      chk("rst_sclk", sclkv[i], 32'(i == 1));
      chk("rst_mosi", mosiv[i], 0);
      chk("rst_rx", rxd[i], 0);
      chk("rst_done", fdone[i], 0);
      chk("rst_ovr", ovr[i], 0);
      chk("rst_init", initd[i], 0);
      chk("rst_busy", busyv[i], 1);
      chk("rst_state", st[i], 0);
    end

    rstn = 2'b11;
    measure_reset(0);
    chk("b_init_done", initd[1], 1);
    chk("b_state", st[1], 2);

    for (int v = 0; v < 4; v++)
      for (int i = 0; i < 2; i++)
        run_frame(i, tbl[v].tx, tbl[v].miso,
                  tbl[v].exp_rx, tbl[v].exp_mosi);

    // Trigger during SHIFT is dropped with a single overrun pulse
    pat[0]  = 16'hC3A5;
    txd[0]  = 16'h0F0F;
    freq[0] = 1'b1;
    tick();
    freq[0] = 1'b0;
    novr = 0;
    nd   = 0;
    nlow = 0;
    seen = 1'b0;
    for (int k = 2; k <= 60; k++) begin
      if (k == 17) freq[0] = 1'b1;
      if (k == 18) freq[0] = 1'b0;
      tick();
      novr += int'(ovr[0]);
      nd   += int'(fdone[0]);
      if (seen && !csv[0]) nlow++;
      if (fdone[0]) seen = 1'b1;
    end
    chk("ovr_pulses", novr, 1);
    chk("frames_done", nd, 1);
    chk("cs_low_after", nlow, 0);
    chk("ovr_rx", rxd[0], 16'hC3A5);

    // Back-to-back request: CS must stay high through the gap
    freq[0] = 1'b1;
    tick();
    freq[0] = 1'b0;
    n = 1;
    while (!fdone[0] && n < 200) begin
      tick();
      n++;
    end
    chk("b2b_latency", n, 37);
    freq[0] = 1'b1;
    n = 0;
    while (csv[0] && n < 50) begin
      tick();
      n++;
    end
    chk("gap_cycles", n, 5);
    freq[0] = 1'b0;
    n = 0;
    while (!fdone[0] && n < 200) begin
      tick();
      n++;
    end
    chk("b2b_second_lat", n, 36);
    chk("b2b_rx", rxd[0], 16'hC3A5);
    wait_idle(0);

    // DRDY fall ignored when AUTO_DRDY=0
    drdy[0] = 1'b0;
    repeat (6) tick();
    chk("a_drdy_cs", csv[0], 1);
    chk("a_drdy_busy", busyv[0], 0);
    drdy[0] = 1'b1;

    // DRDY fall triggers a frame when AUTO_DRDY=1
    pat[1]  = 16'h5AA5;
    txd[1]  = 16'h1234;
    drdy[1] = 1'b0;
    n = 0;
    while (csv[1] && n < 20) begin
      tick();
      n++;
    end
    chk("drdy_to_cs", n, 3);
    n = 0;
    while (!fdone[1] && n < 200) begin
      tick();
      n++;
    end
    chk("drdy_frame_lat", n, 36);
    chk("drdy_rx", rxd[1], 16'h5AA5);
    chk("drdy_mosi", mcap[1], 16'h1234);
    drdy[1] = 1'b1;
    wait_idle(1);

    for (int r = 0; r < 16; r++) begin
      ri = int'($urandom_range(1, 0));
      rt = 16'($urandom);
      rp = 16'($urandom);
      run_frame(ri, rt, rp, rp, rt);
    end

    // adc_init in IDLE reruns the reset sequence
    ainit[1] = 1'b1;
    tick();
    ainit[1] = 1'b0;
    chk("init_clr", initd[1], 0);
    chk("init_state", st[1], 0);
    chk("init_spi_rst", spirst[1], 0);
    chk("init_busy", busyv[1], 1);
    measure_reset(1);

    // Async reset mid-frame aborts without frame_done
    pat[0]  = 16'hFFFF;
    txd[0]  = 16'h1111;
    freq[0] = 1'b1;
    tick();
    freq[0] = 1'b0;
    repeat (13) tick();
    chk("abort_in_shift", st[0], 4);
    rstn[0] = 1'b0;
    #1;
    chk("abort_cs", csv[0], 1);
    chk("abort_state", st[0], 0);
    chk("abort_rx", rxd[0], 0);
    chk("abort_spi_rst", spirst[0], 0);
    chk("abort_sclk", sclkv[0], 0);
    nd = 0;
    repeat (4) begin
      tick();
      nd += int'(fdone[0]);
    end
    rstn[0] = 1'b1;
    measure_reset(0);
    chk("abort_no_done", nd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
